// File: rtl/irq_controller_pkg.sv
// Shared system-register indices, PCS bit positions and controller state encodings.
package irq_controller_pkg;

  localparam logic [1:0] SR_PCS   = 2'd0;
  localparam logic [1:0] SR_IRA   = 2'd1;
  localparam logic [1:0] SR_IDN   = 2'd2;
  localparam logic [1:0] SR_IMASK = 2'd3;

  localparam int PCS_IE  = 0;
  localparam int PCS_OIE = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_HANDLER = 2'd2
  } irq_state_t;

  // Index width that stays legal for a single-entry range.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder; purely combinational, vld says any request is set.
module irq_prio_enc
  import irq_controller_pkg::*;
#(
  parameter int NSRC = 4,
  parameter int IW   = idx_bits(NSRC)
) (
  input  logic [NSRC-1:0] req,
  output logic [IW-1:0]   idx,
  output logic            vld
);

  always_comb begin
    idx = '0;
    vld = |req;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Edge-latching interrupt controller with PCS/IRA/IDN/IMASK system registers.
// take is combinational; after a take no new take occurs for FLUSH_CYC cycles.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int               DBITS      = 16,
  parameter int               NSRC       = 4,
  parameter logic [DBITS-1:0] HANDLER_PC = 16'h0020,
  parameter int               FLUSH_CYC  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NSRC-1:0]  irq_src,
  input  logic             safe,
  input  logic [DBITS-1:0] cur_pc,
  output logic             take,
  output logic [DBITS-1:0] handler_pc,
  input  logic             reti,
  output logic [DBITS-1:0] ret_pc,
  input  logic [1:0]       sr_rd_idx,
  output logic [DBITS-1:0] sr_rd_data,
  input  logic             sr_we,
  input  logic [1:0]       sr_wr_idx,
  input  logic [DBITS-1:0] sr_wr_data,
  output logic [NSRC-1:0]  irq_pending
);

  localparam int IW = idx_bits(NSRC);
  localparam int CW = idx_bits(FLUSH_CYC);

  irq_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ie_q, ie_d, oie_q, oie_d;
  logic [DBITS-1:0] ira_q, ira_d;
  logic [IW-1:0]    idn_q, idn_d;
  logic [NSRC-1:0]  imask_q, imask_d;
  logic [NSRC-1:0]  pending_q, pending_d;
  logic [NSRC-1:0]  prev_src_q, prev_src_d;

  logic [NSRC-1:0]  rise, masked, clr;
  logic [IW-1:0]    enc_idx;
  logic             enc_vld;
  logic             unused_wr_bits;

  assign unused_wr_bits = ^sr_wr_data;

  irq_prio_enc #(.NSRC(NSRC), .IW(IW)) u_enc (
    .req (masked),
    .idx (enc_idx),
    .vld (enc_vld)
  );

  always_comb begin
    rise   = irq_src & ~prev_src_q;
    masked = pending_q & imask_q;
    take   = (state_q == ST_IDLE || state_q == ST_HANDLER) && ie_q && enc_vld && safe && !reti;
    clr    = take ? (NSRC'(1) << enc_idx) : '0;

    prev_src_d = irq_src;
    // A fresh edge on the source being acknowledged keeps it pending.
    pending_d  = (pending_q & ~clr) | rise;
    state_d    = state_q;
    cnt_d      = cnt_q;
    ie_d       = ie_q;
    oie_d      = oie_q;
    ira_d      = ira_q;
    idn_d      = idn_q;
    imask_d    = imask_q;

    if (reti) ie_d = oie_q;

    if (sr_we) begin
      case (sr_wr_idx)
        SR_PCS: begin
          ie_d  = sr_wr_data[PCS_IE];
          oie_d = sr_wr_data[PCS_OIE];
        end
        SR_IRA:   ira_d   = sr_wr_data;
        SR_IDN:   idn_d   = sr_wr_data[IW-1:0];
        SR_IMASK: imask_d = sr_wr_data[NSRC-1:0];
        default:  ;
      endcase
    end

    // Ordered last so the take snapshot beats any same-cycle register write.
    if (take) begin
      ira_d   = cur_pc;
      idn_d   = enc_idx;
      oie_d   = ie_q;
      ie_d    = 1'b0;
      state_d = ST_DRAIN;
      cnt_d   = CW'(FLUSH_CYC - 1);
    end else begin
      case (state_q)
        ST_DRAIN: begin
          if (cnt_q == '0) state_d = ST_HANDLER;
          else             cnt_d   = cnt_q - 1'b1;
        end
        ST_HANDLER: if (reti) state_d = ST_IDLE;
        default: ;
      endcase
    end
  end

  always_comb begin
    sr_rd_data = '0;
    case (sr_rd_idx)
      SR_PCS: begin
        sr_rd_data[PCS_IE]  = ie_q;
        sr_rd_data[PCS_OIE] = oie_q;
      end
      SR_IRA:   sr_rd_data = ira_q;
      SR_IDN:   sr_rd_data = DBITS'(idn_q);
      SR_IMASK: sr_rd_data = DBITS'(imask_q);
      default:  ;
    endcase
  end

  assign handler_pc  = HANDLER_PC;
  assign ret_pc      = ira_q;
  assign irq_pending = pending_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ie_q       <= 1'b0;
      oie_q      <= 1'b0;
      ira_q      <= '0;
      idn_q      <= '0;
      imask_q    <= '0;
      pending_q  <= '0;
      prev_src_q <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ie_q       <= ie_d;
      oie_q      <= oie_d;
      ira_q      <= ira_d;
      idn_q      <= idn_d;
      imask_q    <= imask_d;
      pending_q  <= pending_d;
      prev_src_q <= prev_src_d;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller; a monitor pops expected take records and checks IRA/pending.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_src;
  logic        safe;
  logic [15:0] cur_pc;
  logic        take;
  logic [15:0] handler_pc;
  logic        reti;
  logic [15:0] ret_pc;
  logic [1:0]  sr_rd_idx;
  logic [15:0] sr_rd_data;
  logic        sr_we;
  logic [1:0]  sr_wr_idx;
  logic [15:0] sr_wr_data;
  logic [3:0]  irq_pending;

  typedef struct {
    logic [15:0] pc;
    logic [3:0]  pend;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_exp;
  bit   chk_vld = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  irq_controller dut (
    .clk         (clk),
    .reset       (reset),
    .irq_src     (irq_src),
    .safe        (safe),
    .cur_pc      (cur_pc),
    .take        (take),
    .handler_pc  (handler_pc),
    .reti        (reti),
    .ret_pc      (ret_pc),
    .sr_rd_idx   (sr_rd_idx),
    .sr_rd_data  (sr_rd_data),
    .sr_we       (sr_we),
    .sr_wr_idx   (sr_wr_idx),
    .sr_wr_data  (sr_wr_data),
    .irq_pending (irq_pending)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every take consumes one expected record; one cycle later IRA and pending are compared.
  always @(negedge clk) begin
    if (reset) begin
      chk_vld = 1'b0;
    end else begin
      if (chk_vld) begin
        check("mon_ret_pc", ret_pc, cur_exp.pc);
        check("mon_pending", irq_pending, cur_exp.pend);
        chk_vld = 1'b0;
      end
      if (take) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL mon_unexpected_take: got take=1 expected no take at %0t", $time);
        end else begin
          cur_exp = exp_q.pop_front();
          chk_vld = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wsr(input logic [1:0] idx, input logic [15:0] data);
    sr_we = 1'b1; sr_wr_idx = idx; sr_wr_data = data;
    tick();
    sr_we = 1'b0;
  endtask

  task automatic rsr(input string name, input logic [1:0] idx, input logic [15:0] exp);
    sr_rd_idx = idx;
    #1;
    check(name, sr_rd_data, exp);
  endtask

  task automatic push_exp(input logic [15:0] pc, input logic [3:0] pend);
    exp_t e;
    e.pc = pc; e.pend = pend;
    exp_q.push_back(e);
  endtask

  task automatic wait_take(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_take"}, take, 0);
    check({tag, "_pending"}, irq_pending, 0);
    check({tag, "_ret_pc"}, ret_pc, 0);
    for (int i = 0; i < 4; i++) rsr({tag, "_sr"}, 2'(i), 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; irq_src = 4'h0; safe = 1'b0; cur_pc = 16'h0; reti = 1'b0;
    sr_rd_idx = 2'd0; sr_we = 1'b0; sr_wr_idx = 2'd0; sr_wr_data = 16'h0;
    #2;
    // 1: reset state
    check_all_zero("rst");
    check("handler_pc", handler_pc, 16'h0020);
    tick(); tick();
    reset = 1'b0;
    tick();

    // 2: single source take
    wsr(2'd3, 16'h0001);
    wsr(2'd0, 16'h0001);
    rsr("t2_pcs_pre", 2'd0, 16'h0001);
    push_exp(16'h0214, 4'b0000);
    safe = 1'b1; cur_pc = 16'h0214; irq_src = 4'b0001;
    #1 check("t2_no_take_same_cycle", take, 0);
    tick();
    check("t2_take_latency", take, 1);
    wait_take("t2_take", 5);
    irq_src = 4'b0000;
    check("t2_take_one_cycle", take, 0);
    rsr("t2_idn", 2'd2, 16'h0000);
    rsr("t2_pcs", 2'd0, 16'h0002);
    rsr("t2_ira", 2'd1, 16'h0214);
    tick(); tick(); tick();  // now in HANDLER

    // 3: nested take from HANDLER, priority, reti
    wsr(2'd3, 16'h0006);
    wsr(2'd0, 16'h0001);
    push_exp(16'h0300, 4'b0100);
    cur_pc = 16'h0300; irq_src = 4'b0110;
    tick();
    check("t3_take_nested", take, 1);
    wait_take("t3_take1", 5);
    irq_src = 4'b0000;
    rsr("t3_idn1", 2'd2, 16'h0001);
    rsr("t3_pcs_after_take", 2'd0, 16'h0002);
    tick(); tick(); tick();
    push_exp(16'h0310, 4'b0000);
    cur_pc = 16'h0310; reti = 1'b1;
    #1 check("t3_no_take_during_reti", take, 0);
    tick();
    reti = 1'b0;
    sr_rd_idx = 2'd0;
    #1 check("t3_ie_after_reti", sr_rd_data[0], 1);
    check("t3_take_after_reti", take, 1);
    wait_take("t3_take2", 5);
    rsr("t3_idn2", 2'd2, 16'h0002);
    tick(); tick(); tick();

    // 4: safe=0 holds the request
    safe = 1'b0; reti = 1'b1;
    tick();
    reti = 1'b0; irq_src = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_take_blocked", take, 0);
    end
    check("t4_pending_held", irq_pending, 4'b0010);
    push_exp(16'h0400, 4'b0000);
    cur_pc = 16'h0400; safe = 1'b1;
    #1 check("t4_take_on_safe", take, 1);
    wait_take("t4_take", 5);

    // 5: drain window blocks take even with IE re-enabled
    sr_we = 1'b1; sr_wr_idx = 2'd0; sr_wr_data = 16'h0001; irq_src = 4'b0100;
    #1 check("t5_drain1", take, 0);
    tick();
    sr_we = 1'b0;
    check("t5_drain2", take, 0);
    tick();
    check("t5_drain3", take, 0);
    push_exp(16'h0500, 4'b0000);
    cur_pc = 16'h0500;
    tick();
    check("t5_take_handler", take, 1);
    wait_take("t5_take", 5);

    // 6: reset mid-DRAIN with sources held high
    irq_src = 4'b1111;
    tick();
    check("t6_pending_before_reset", irq_pending, 4'b1011);
    reset = 1'b1;
    #1 check_all_zero("t6_rst");
    tick(); tick();
    reset = 1'b0;
    tick();
    wsr(2'd3, 16'h000F);
    wsr(2'd0, 16'h0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_no_take_held_src", take, 0);
    end
    check("t6_pending_zero", irq_pending, 4'b0000);

    check("exp_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
